// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: word size, reset PC,
// fetch exception codes, FSM state encoding and the IF/ID entry layout.
package ifetch_ctrl_pkg;

    localparam int unsigned WORDSIZE = 32;
    localparam logic [WORDSIZE-1:0] PCBASE = 32'h0040_0000;

    localparam logic [8:0] EXC_NONE      = 9'h000;
    localparam logic [8:0] EXC_IMISALIGN = 9'h002;
    localparam logic [8:0] EXC_IBUS      = 9'h004;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [WORDSIZE-1:0] instr;
        logic [WORDSIZE-1:0] pc;
        logic                valid;
        logic [8:0]          exc;
    } ifid_t;

    function automatic ifid_t make_entry(
        input logic [WORDSIZE-1:0] instr,
        input logic [WORDSIZE-1:0] pc,
        input logic [8:0]          exc
    );
        ifid_t e;
        e.instr = instr;
        e.pc    = pc;
        e.valid = 1'b1;
        e.exc   = exc;
        return e;
    endfunction

endpackage

// File: rtl/ifetch_ctrl_ifid_reg.sv
// IF/ID pipeline register: clear wins over load, otherwise holds its contents.
module ifid_reg
    import ifetch_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clear,
    input  ifid_t entry,
    output ifid_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= entry;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: single outstanding imem request, decode-stall
// hold buffer and redirect handling. FETCH_TIMEOUT_EN enables the bus timeout.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORDSIZE-1:0] pc,
    input  logic                installD,
    input  logic                flushD,
    output logic                imem_req,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [WORDSIZE-1:0] imem_rdata,
    output logic                installF,
    output logic [WORDSIZE-1:0] instrD,
    output logic [WORDSIZE-1:0] pcD,
    output logic                validD,
    output logic [8:0]          exceptionD
);

    fetch_state_t        state, state_next;
    logic [WORDSIZE-1:0] addr_q;
    ifid_t               hold_q;

    logic                req;
    logic [WORDSIZE-1:0] addr_out;
    logic                stall;
    logic                issue;
    logic                timeout;
    logic                ifid_load, ifid_clear;
    ifid_t               ifid_entry;
    logic                hold_load;
    ifid_t               hold_entry;
    ifid_t               resp_entry;
    ifid_t               ifid_q;

    // A bus timeout is delivered like a response carrying EXC_IBUS.
    assign resp_entry = imem_rvalid ? make_entry(imem_rdata, addr_q, EXC_NONE)
                                    : make_entry('0, addr_q, EXC_IBUS);

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q;
    logic       waiting;

    assign waiting = (state == S_WAIT) || (state == S_DROP);
    assign timeout = waiting && (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (!waiting || (state_next != state)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        req        = 1'b0;
        addr_out   = addr_q;
        stall      = 1'b0;
        issue      = 1'b0;
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        ifid_entry = '0;
        hold_load  = 1'b0;
        hold_entry = '0;

        unique case (state)
            S_REQ: begin
                if (flushD) begin
                    ifid_clear = 1'b1;
                end else if (installD) begin
                    stall = 1'b1;
                end else if (pc[1:0] != 2'b00) begin
                    ifid_load  = 1'b1;
                    ifid_entry = make_entry('0, pc, EXC_IMISALIGN);
                end else begin
                    req        = 1'b1;
                    addr_out   = pc;
                    issue      = 1'b1;
                    stall      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                req   = 1'b1;
                stall = 1'b1;
                if (flushD) begin
                    ifid_clear = 1'b1;
                    stall      = 1'b0;
                    state_next = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid || timeout) begin
                    if (installD) begin
                        hold_load  = 1'b1;
                        hold_entry = resp_entry;
                        state_next = S_HOLD;
                    end else begin
                        ifid_load  = 1'b1;
                        ifid_entry = resp_entry;
                        stall      = 1'b0;
                        state_next = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                stall = 1'b1;
                if (flushD) begin
                    ifid_clear = 1'b1;
                    stall      = 1'b0;
                    state_next = S_REQ;
                end else if (!installD) begin
                    // Release the PC on the drain cycle so the held word is not refetched.
                    ifid_load  = 1'b1;
                    ifid_entry = hold_q;
                    stall      = 1'b0;
                    state_next = S_REQ;
                end
            end
            S_DROP: begin
                stall = 1'b1;
                if (flushD) begin
                    ifid_clear = 1'b1;
                    stall      = 1'b0;
                end
                if (imem_rvalid || timeout) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_REQ;
            addr_q <= '0;
            hold_q <= '0;
        end else begin
            state <= state_next;
            if (issue) begin
                addr_q <= pc;
            end
            if (hold_load) begin
                hold_q <= hold_entry;
            end
        end
    end

    // Combinational outputs are gated so reset forces them low immediately.
    assign imem_req  = rst & req;
    assign imem_addr = rst ? addr_out : '0;
    assign installF  = rst & stall;

    ifid_reg u_ifid (
        .clk   (clk),
        .rst   (rst),
        .load  (ifid_load),
        .clear (ifid_clear),
        .entry (ifid_entry),
        .q     (ifid_q)
    );

    assign instrD     = ifid_q.instr;
    assign pcD        = ifid_q.pc;
    assign validD     = ifid_q.valid;
    assign exceptionD = ifid_q.exc;

endmodule
